// File: rtl/pipe_ctrl_n.sv
// Pipeline controller: per-register hold/clear, memory wait/timeout FSM, replayed pending jump. Optional PIPE_CTRL_PERF_EN adds perf counters.
// Latency: all hold/clear/jump outputs are combinational from state plus live inputs (0 cycles); err_o is registered.
// Backpressure: hold_i / mem_busy_i / error lock stall the whole pipe; a jump seen while stalled is latched and issued on the first free cycle.
module pipe_ctrl_n #(
  parameter int STAGES      = 5,
  parameter int ADDR_W      = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int HAZ_STAGE   = 2,
  parameter int WAIT_MAX    = 255
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              hold_i,
  input  logic              mem_busy_i,
  input  logic              hazard_i,
  input  logic              jump_ena_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [STAGES-1:0] stage_hold_o,
  output logic [STAGES-1:0] stage_clr_o,
  output logic              jump_ena_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  // Bit mask with bits lo..hi set
  function automatic logic [STAGES-1:0] range_mask(input int lo, input int hi);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STAGES-1:0] FLUSH_MASK   = range_mask(1, FLUSH_DEPTH);
  localparam logic [STAGES-1:0] HAZ_HOLD_MSK = range_mask(0, HAZ_STAGE - 1);
  localparam logic [STAGES-1:0] HAZ_CLR_MSK  = range_mask(HAZ_STAGE, HAZ_STAGE);

  // Reject configurations whose flush or bubble position falls outside the pipe
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES - 1) begin : g_bad_flush
    $error("pipe_ctrl_n: FLUSH_DEPTH out of range 1..STAGES-1");
  end
  if (HAZ_STAGE < 1 || HAZ_STAGE > STAGES - 1) begin : g_bad_haz
    $error("pipe_ctrl_n: HAZ_STAGE out of range 1..STAGES-1");
  end

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            st;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic              stalled;

  // Any condition that freezes the whole pipe; jumps are deferred while it holds
  assign stalled = (st == ERR) || hold_i || mem_busy_i;

  // Output priority: reset, stall, live jump, pending jump, hazard bubble
  always_comb begin
    stage_hold_o = '0;
    stage_clr_o  = '0;
    jump_ena_o   = 1'b0;
    jump_addr_o  = '0;
    if (!arst_n) begin
      stage_clr_o = '1;
    end else if (stalled) begin
      stage_hold_o = '1;
    end else if (jump_ena_i) begin
      jump_ena_o  = 1'b1;
      jump_addr_o = jump_addr_i;
      stage_clr_o = FLUSH_MASK;
    end else if (pend_v) begin
      jump_ena_o  = 1'b1;
      jump_addr_o = pend_addr;
      stage_clr_o = FLUSH_MASK;
    end else if (hazard_i) begin
      stage_hold_o = HAZ_HOLD_MSK;
      stage_clr_o  = HAZ_CLR_MSK;
    end
  end

  // Wait-state FSM: counts consecutive busy cycles, locks into ERR on timeout.
  // A hold with memory idle keeps the count so a resumed wait still times out.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      st       <= RUN;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else if (st != ERR) begin
      if (mem_busy_i && wait_cnt == CNT_LAST) begin
        st    <= ERR;
        err_o <= 1'b1;
      end else if (hold_i) begin
        st <= HALT;
      end else if (mem_busy_i) begin
        st <= WAIT;
      end else begin
        st <= RUN;
      end
      if (mem_busy_i) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else if (!hold_i) begin
        wait_cnt <= '0;
      end
    end
  end

  // Pending jump: latch newest request while stalled, drop once issued
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (stalled) begin
      if (jump_ena_i) begin
        pend_v    <= 1'b1;
        pend_addr <= jump_addr_i;
      end
    end else if (jump_ena_i || pend_v) begin
      pend_v <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating stall and flush event counters
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((|stage_hold_o) && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_ena_o && flush_cnt_o != 32'hFFFF_FFFF) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
